// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like responder: protocol widths, latency
// counter width and the FSM state encoding.
package sram_like_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_BUS_W = 32;
    localparam int BE_W       = 4;
    localparam int LAT_W      = 4;
    localparam int LAT_MAX    = (1 << LAT_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Any nonzero byte-enable pattern is a request.
    function automatic logic is_request(input logic [BE_W-1:0] cen);
        return |cen;
    endfunction

endpackage

// File: rtl/sram_like_mem.sv
// Synchronous single-port word RAM with per-byte write enables.
// A read in the same cycle as a write to the same word returns the old data.
module sram_like_mem
    import sram_like_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    input  logic [BE_W-1:0]   we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Output register only moves on a read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata <= mem[addr];
        end
        for (int i = 0; i < BE_W; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/sram_like_resp.sv
// Responder for the SRAM-like request/ack/rrdy port: one outstanding
// transaction, byte-enabled access to an internal RAM, programmable latency.
module sram_like_resp
    import sram_like_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        hrst,
    input  logic [3:0]  sram_cen,
    input  logic        sram_wr,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic        sram_ack,
    output logic        sram_rrdy,
    output logic [31:0] sram_rdata,
    output logic [1:0]  dbg_state
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("sram_like_resp: LATENCY %0d outside 1..%0d", LATENCY, LAT_MAX);
    end
    if (ADDR_W < 1 || ADDR_W > ADDR_BUS_W - 3) begin : g_bad_addr_w
        $error("sram_like_resp: ADDR_W %0d unsupported", ADDR_W);
    end

    // Valid/ready contract: the initiator raises sram_cen and holds it with
    // addr/wr/wdata stable until sram_ack; sram_rrdy later closes the
    // transaction, and only then is a new request sampled (in IDLE).

    state_t            state, state_n;
    logic [LAT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [BE_W-1:0]   cen_q;
    logic [DATA_W-1:0] wdata_q;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [BE_W-1:0]   mem_we;
    logic [DATA_W-1:0] mem_q;

    logic              req;
    logic              unused_addr_bits;

    assign req              = is_request(sram_cen);
    assign unused_addr_bits = ^{sram_addr[ADDR_BUS_W-1:ADDR_W+2], sram_addr[1:0]};
    assign dbg_state        = state;

    always_ff @(posedge clk) begin
        if (!hrst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sram_ack   <= 1'b0;
            sram_rrdy  <= 1'b0;
            sram_rdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sram_ack  <= (state_n == ST_ACK);
            sram_rrdy <= (state_n == ST_RESP);
            // Read data lands with rrdy; write completions leave it untouched.
            if (state_n == ST_RESP && !wr_q) begin
                sram_rdata <= mem_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!hrst) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            cen_q   <= '0;
            wdata_q <= '0;
        end else if (state == ST_IDLE && req) begin
            addr_q  <= sram_addr[ADDR_W+1:2];
            wr_q    <= sram_wr;
            cen_q   <= sram_cen;
            wdata_q <= sram_wdata;
        end
    end

    // The RAM read is launched as the request is accepted so its registered
    // output is ready by ACK; writes happen in ACK, so the two never overlap.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mem_addr = addr_q;
        mem_rd   = 1'b0;
        mem_we   = '0;
        case (state)
            ST_IDLE: begin
                mem_addr = sram_addr[ADDR_W+1:2];
                if (req) begin
                    state_n = ST_ACK;
                    mem_rd  = !sram_wr;
                end
            end
            ST_ACK: begin
                if (wr_q) begin
                    mem_we = cen_q;
                end
                cnt_n   = LAT_LOAD;
                state_n = (LAT_LOAD == '0) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_n = cnt - 1'b1;
                if (cnt <= LAT_W'(1)) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    sram_like_mem #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk   (clk),
        .addr  (mem_addr),
        .rd_en (mem_rd),
        .we    (mem_we),
        .wdata (wdata_q),
        .rdata (mem_q)
    );

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: four instances at LATENCY 1, 3, 15 and 5, driven
// one transaction at a time with read data checked through an expected queue.
module tb_sram_like_resp;

    localparam int N_INST = 4;

    logic        clk;
    logic        hrst  [N_INST];
    logic [3:0]  cen   [N_INST];
    logic        wr    [N_INST];
    logic [31:0] addr  [N_INST];
    logic [31:0] wdata [N_INST];
    logic        ack   [N_INST];
    logic        rrdy  [N_INST];
    logic [31:0] rdata [N_INST];
    logic [1:0]  dbg   [N_INST];

    logic [31:0] exp_q[$];
    int total;
    int bad;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        sram_like_resp #(
            .ADDR_W  (12),
            .LATENCY (g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 15 : 5)
        ) u_dut (
            .clk        (clk),
            .hrst       (hrst[g]),
            .sram_cen   (cen[g]),
            .sram_wr    (wr[g]),
            .sram_addr  (addr[g]),
            .sram_wdata (wdata[g]),
            .sram_ack   (ack[g]),
            .sram_rrdy  (rrdy[g]),
            .sram_rdata (rdata[g]),
            .dbg_state  (dbg[g])
        );
    end

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 15;
            default: return 5;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic do_txn(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          input logic [31:0] rd_exp);
        int n;
        int extra;
        logic [31:0] e;
        @(negedge clk);
        cen[k]   = be;
        wr[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        if (!w) exp_q.push_back(rd_exp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[k] !== 1'b1 && n < 20);
        check($sformatf("ack_lat[%0d]", k), n, 1);
        cen[k] = 4'h0;
        wr[k]  = 1'b0;
        n = 0;
        extra = 0;
        do begin
            @(negedge clk);
            n++;
            if (ack[k] !== 1'b0) extra++;
        end while (rrdy[k] !== 1'b1 && n < 40);
        check($sformatf("rrdy_lat[%0d]", k), n, lat_of(k));
        check($sformatf("ack_extra[%0d]", k), extra, 0);
        if (!w && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("rdata[%0d]@%h", k, a), rdata[k], e);
        end
        @(negedge clk);
        check($sformatf("rrdy_pulse[%0d]", k), rrdy[k], 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int seen;
        logic [31:0] ra;
        logic [31:0] rd;
        total = 0;
        bad   = 0;
        for (int i = 0; i < N_INST; i++) begin
            hrst[i]  = 1'b0;
            cen[i]   = 4'h0;
            wr[i]    = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
        end
        // Reset held for 3 cycles while a write request is already asserted.
        cen[0]   = 4'hF;
        wr[0]    = 1'b1;
        addr[0]  = 32'h300;
        wdata[0] = 32'h0BAD_F00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ack", ack[0], 0);
            check("rst_rrdy", rrdy[0], 0);
            check("rst_rdata", rdata[0], 0);
        end
        check("rst_state1", dbg[1], 0);
        check("rst_rdata3", rdata[3], 0);
        for (int i = 0; i < N_INST; i++) hrst[i] = 1'b1;
        @(negedge clk);
        check("post_rst_ack", ack[0], 1);
        cen[0] = 4'h0;
        wr[0]  = 1'b0;
        @(negedge clk);
        check("post_rst_rrdy", rrdy[0], 1);
        check("post_rst_ack_low", ack[0], 0);
        @(negedge clk);
        check("post_rst_rrdy_low", rrdy[0], 0);

        // Write then read, byte enables, aliasing and held read data.
        do_txn(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, '0);
        do_txn(0, 1'b0, 32'h100, '0, 4'hF, 32'hDEAD_BEEF);
        do_txn(0, 1'b1, 32'h200, 32'h1122_3344, 4'hF, '0);
        do_txn(0, 1'b1, 32'h200, 32'hAABB_CCDD, 4'b0101, '0);
        do_txn(0, 1'b0, 32'h200, '0, 4'hF, 32'h11BB_33DD);
        do_txn(0, 1'b1, 32'h4000, 32'h5A5A_5A5A, 4'hF, '0);
        do_txn(0, 1'b0, 32'h0000, '0, 4'hF, 32'h5A5A_5A5A);
        do_txn(0, 1'b1, 32'h0004, 32'h0, 4'hF, '0);
        check("rdata_held", rdata[0], 32'h5A5A_5A5A);
        do_txn(0, 1'b0, 32'h300, '0, 4'b0010, 32'h0BAD_F00D);

        // Random full-word write/read pairs; read enables must not mask data.
        for (int i = 0; i < 4; i++) begin
            ra = 32'($urandom_range(32'h400, 32'h7FF)) & 32'hFFFF_FFFC;
            rd = $urandom;
            do_txn(0, 1'b1, ra, rd, 4'hF, '0);
            do_txn(0, 1'b0, ra | 32'($urandom_range(0, 3)), '0,
                   4'($urandom_range(1, 15)), rd);
        end

        // Latency sweep.
        do_txn(1, 1'b1, 32'h10, 32'h1357_9BDF, 4'hF, '0);
        do_txn(1, 1'b0, 32'h10, '0, 4'hF, 32'h1357_9BDF);
        do_txn(2, 1'b1, 32'h20, 32'h2468_ACE0, 4'hF, '0);
        do_txn(2, 1'b0, 32'h20, '0, 4'hF, 32'h2468_ACE0);

        // Reset two cycles after the ack of a write: no rrdy, write kept.
        @(negedge clk);
        cen[3]   = 4'hF;
        wr[3]    = 1'b1;
        addr[3]  = 32'h80;
        wdata[3] = 32'hCAFE_F00D;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[3] !== 1'b1 && n < 20);
        check("midop_ack_lat", n, 1);
        cen[3] = 4'h0;
        wr[3]  = 1'b0;
        seen = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rrdy[3] === 1'b1) seen++;
        end
        hrst[3] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rrdy[3] === 1'b1) seen++;
        end
        hrst[3] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rrdy[3] === 1'b1) seen++;
        end
        check("midop_rrdy", seen, 0);
        check("midop_state", dbg[3], 0);
        check("midop_rdata", rdata[3], 0);
        do_txn(3, 1'b0, 32'h80, '0, 4'hF, 32'hCAFE_F00D);

        check("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
